// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int SA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Gate-level one-bit full-adder cell used as the serial datapath.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic ab_x_s;
  logic ab_a_s;
  logic cx_a_s;

  xor g_x0 (ab_x_s, a_i, b_i);
  xor g_x1 (s_o, ab_x_s, ci_i);
  and g_a0 (ab_a_s, a_i, b_i);
  and g_a1 (cx_a_s, ab_x_s, ci_i);
  or  g_o0 (co_o, ab_a_s, cx_a_s);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: accepts A+B+CIN, adds one bit per cycle LSB first,
// and holds the result under a valid/ready handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             abort_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o
);

  localparam int                CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_sum_s;
  logic             fa_cout_s;

  full_adder u_fa (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_sum_s),
    .co_o (fa_cout_s)
  );

  // State, operand, result, carry and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update; abort outranks the final RUN step.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = RUN;
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          res_d   = {fa_sum_s, res_q[WIDTH-1:1]};
          a_d     = {1'b0, a_q[WIDTH-1:1]};
          b_d     = {1'b0, b_q[WIDTH-1:1]};
          carry_d = fa_cout_s;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign sum_o       = res_q;
  assign cout_o      = carry_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default 8, SHALL set the operand width in bits, legal range 2..64.
REQ-003 Port CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port RST_N  input  1  SHALL be the asynchronous active-low reset.
REQ-005 Port IN_VALID  input  1  SHALL flag that A, B and CIN hold a valid operation.
REQ-006 Port IN_READY  output  1  SHALL flag that the block accepts an operation this cycle.
REQ-007 Port A  input  WIDTH  SHALL be operand A.
REQ-008 Port B  input  WIDTH  SHALL be operand B.
REQ-009 Port CIN  input  1  SHALL be the carry into bit 0.
REQ-010 Port ABORT  input  1  SHALL be a synchronous cancel of an operation in progress.
REQ-011 Port OUT_VALID  output  1  SHALL flag that SUM and COUT hold a valid result.
REQ-012 Port OUT_READY  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-013 Port SUM  output  WIDTH  SHALL be A+B+CIN modulo 2^WIDTH.
REQ-014 Port COUT  output  1  SHALL be the carry out of bit WIDTH-1.
REQ-015 Port BUSY  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-017 In IDLE, IN_READY SHALL be 1; in RUN and DONE, IN_READY SHALL be 0.
REQ-018 IDLE SHALL go to RUN on IN_VALID&IN_READY and capture A and B into shift registers, CIN into the carry flop, and clear the bit counter.
REQ-019 Each RUN cycle SHALL add the LSBs of both shift registers and the carry flop in one full-adder cell.
REQ-020 Each RUN cycle SHALL shift the sum bit into the MSB of the result register, right-shift both operand registers, load the cell carry into the carry flop, and increment the counter.
REQ-021 RUN SHALL go to DONE on the cycle in which the counter equals WIDTH-1, so exactly WIDTH RUN cycles occur.
REQ-022 OUT_VALID SHALL rise exactly WIDTH cycles after the accepting edge.
REQ-023 In DONE, OUT_VALID SHALL be 1, and SUM and COUT (COUT = carry flop) SHALL stay stable until OUT_VALID&OUT_READY.
REQ-024 DONE SHALL go to IDLE on OUT_VALID&OUT_READY.
REQ-025 OUT_READY held low SHALL hold DONE indefinitely with no loss of the result.
REQ-026 A new operation SHALL be accepted no earlier than the cycle after the result handshake, so there is no overlap.
REQ-027 IN_VALID, A, B and CIN SHALL be ignored outside IDLE.
REQ-028 ABORT in RUN SHALL go to IDLE next cycle with no OUT_VALID pulse.
REQ-029 ABORT in IDLE or DONE SHALL have no effect.
REQ-030 ABORT SHALL take priority over the RUN-to-DONE transition on the same cycle.
REQ-031 OUT_VALID SHALL be 0 in IDLE and RUN.
REQ-032 SUM and COUT SHALL be don't-care while OUT_VALID=0.

Reset
REQ-033 While RST_N=0, the block SHALL be in IDLE, with all shift registers, the counter and the carry flop at 0.
REQ-034 During reset, outputs SHALL be IN_READY=1, OUT_VALID=0, BUSY=0, SUM=0 and COUT=0.
REQ-035 Reset asserted mid-RUN or mid-DONE SHALL discard the operation immediately, with no result emitted after release.

Structure
REQ-036 Package serial_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-037 The counter width SHALL be $clog2(WIDTH).
REQ-038 The bit datapath SHALL instantiate the team's gate-level FULL_ADDER cell as its single sub-module.
REQ-039 All other logic (FSM, shift registers, counter) SHALL be RTL in serial_add_ctrl.

Verification (WIDTH=8)
REQ-040 Bench SHALL cover basic add: A=0x5A, B=0x3C, CIN=0 -> SUM=0x96, COUT=0, OUT_VALID high exactly 8 cycles after acceptance.
REQ-041 Bench SHALL cover carry chain: A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1.
REQ-042 Bench SHALL cover the all-ones case: A=0xFF, B=0xFF, CIN=1 -> SUM=0xFF, COUT=1.
REQ-043 Bench SHALL cover backpressure and ignored input: OUT_READY low 5 cycles after OUT_VALID, plus IN_VALID pulsed during RUN -> result stable for 5 cycles, IN_READY=0 throughout, next acceptance only after the handshake.
REQ-044 Bench SHALL cover abort: ABORT on RUN cycle 4 -> IDLE next cycle, no OUT_VALID; then A=0x10, B=0x20, CIN=0 -> SUM=0x30, COUT=0.
REQ-045 Bench SHALL cover reset mid-operation: RST_N low on RUN cycle 3 -> outputs at reset values immediately, IDLE after release, no stale result.
